// File: rtl/mux_scan_capture_pkg.sv
// Shared constants for the mux scan/capture block: default geometry and FSM encodings.
package mux_scan_capture_pkg;
  localparam int N_CH_DEF  = 4;
  localparam int SEL_W_DEF = 2;
  localparam int DWELL_DEF = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;
endpackage

// File: rtl/mux_scan_capture_if.sv
// Scan bus between the sequencer and its controller/mux: controls and y in, select and word out.
// No handshake: start/cont are level-sampled, done is a single-cycle strobe.
interface mux_scan_capture_if
  import mux_scan_capture_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int SEL_W = SEL_W_DEF
);
  logic             start;
  logic             cont;
  logic             mux_y;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             done;
  logic [N_CH-1:0]  sample;

  modport master (output start, cont, mux_y, input sel, busy, done, sample);
  modport slave  (input start, cont, mux_y, output sel, busy, done, sample);
endinterface

// File: rtl/mux_scan_capture_dwell_timer.sv
// Settle-interval counter: clear has priority over enable, o_tc flags count == DWELL-1.
// One-cycle registered count, combinational terminal-count compare; no backpressure.
module mux_dwell_timer
  import mux_scan_capture_pkg::*;
#(
  parameter int DWELL = DWELL_DEF,
  parameter int CNT_W = $clog2(DWELL) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tc = (r_cnt == CNT_W'(DWELL - 1));
endmodule

// File: rtl/mux_scan_capture.sv
// Steps the mux select through every channel, samples y after DWELL settle cycles, rebuilds the word.
// One word per N_CH*(DWELL+1) cycles plus the DONE cycle; start is ignored while busy.
module mux_scan_capture
  import mux_scan_capture_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int DWELL = DWELL_DEF
) (
  input  logic                clk,
  input  logic                rst,
  mux_scan_capture_if.slave   bus
);
  logic [1:0]       r_state;
  logic [SEL_W-1:0] r_sel;
  logic [N_CH-1:0]  r_shadow;
  logic [N_CH-1:0]  r_sample;
  logic             w_settle;
  logic             w_last;
  logic             w_tc;

  assign w_settle = (r_state == ST_SETTLE);
  assign w_last   = (r_sel == SEL_W'(N_CH - 1));

  // Counter runs only while settling, so it restarts from zero on every channel.
  mux_dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (!w_settle),
    .i_en  (w_settle),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_sel    <= '0;
      r_shadow <= '0;
      r_sample <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= ST_SETTLE;
            r_sel   <= '0;
          end
        end
        ST_SETTLE: begin
          if (w_tc) r_state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          r_shadow[r_sel] <= bus.mux_y;
          if (w_last) begin
            // Last channel's y bypasses the shadow so the word is complete on DONE entry.
            r_sample <= {bus.mux_y, r_shadow[N_CH-2:0]};
            r_state  <= ST_DONE;
          end else begin
            r_sel   <= r_sel + SEL_W'(1);
            r_state <= ST_SETTLE;
          end
        end
        default: begin
          r_sel   <= '0;
          r_state <= bus.cont ? ST_SETTLE : ST_IDLE;
        end
      endcase
    end
  end

  assign bus.sel    = r_sel;
  assign bus.busy   = (r_state != ST_IDLE);
  assign bus.done   = (r_state == ST_DONE);
  assign bus.sample = r_sample;
endmodule

// File: tb/tb_mux_scan_capture.sv
// Directed bench: behavioural 4:1 mux closes the loop from sel back to mux_y.
module tb_mux_scan_capture;
  logic       clk;
  logic       rst;
  logic [3:0] d;
  int         n_pass;
  int         n_total;

  mux_scan_capture_if #(.N_CH(4), .SEL_W(2)) bus ();

  mux_scan_capture #(.N_CH(4), .SEL_W(2), .DWELL(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.mux_y = d[bus.sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b1;
    d         = 4'b0000;
    bus.start = 1'b0;
    bus.cont  = 1'b0;

    // reset state
    tick(2);
    chk("rst_sel",    8'(bus.sel),    8'h0);
    chk("rst_sample", 8'(bus.sample), 8'h0);
    chk("rst_busy",   8'(bus.busy),   8'h0);
    chk("rst_done",   8'(bus.done),   8'h0);
    rst = 1'b0;
    tick(1);

    // single scan of 0110; D disturbed during SETTLE, correct only in SAMPLE cycles
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    for (int j = 0; j < 20; j++) begin
      d = (j % 5 == 4) ? 4'b0110 : 4'b1001;
      chk("scan_sel",  8'(bus.sel),  8'(j / 5));
      chk("scan_busy", 8'(bus.busy), 8'h1);
      chk("scan_done", 8'(bus.done), 8'h0);
      tick(1);
    end
    d = 4'b0110;
    chk("s1_done",   8'(bus.done),   8'h1);
    chk("s1_sample", 8'(bus.sample), 8'h6);
    tick(1);
    chk("s1_done_off", 8'(bus.done),   8'h0);
    chk("s1_idle",     8'(bus.busy),   8'h0);
    chk("s1_sel0",     8'(bus.sel),    8'h0);
    chk("s1_hold",     8'(bus.sample), 8'h6);

    // continuous: 1001 then 0101, done every 21 cycles
    bus.cont  = 1'b1;
    d         = 4'b1001;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(20);
    chk("c1_done",   8'(bus.done),   8'h1);
    chk("c1_sample", 8'(bus.sample), 8'h9);
    d = 4'b0101;
    tick(1);
    chk("c2_busy", 8'(bus.busy), 8'h1);
    chk("c2_sel0", 8'(bus.sel),  8'h0);
    tick(19);
    chk("c2_early", 8'(bus.done), 8'h0);
    bus.cont = 1'b0;
    tick(1);
    chk("c2_done",   8'(bus.done),   8'h1);
    chk("c2_sample", 8'(bus.sample), 8'h5);
    tick(1);
    chk("c2_idle", 8'(bus.busy), 8'h0);

    // reset while sel==2 aborts the scan and clears sample
    d         = 4'b1111;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(10);
    chk("ab_sel2", 8'(bus.sel), 8'h2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("ab_busy",   8'(bus.busy),   8'h0);
    chk("ab_sel",    8'(bus.sel),    8'h0);
    chk("ab_sample", 8'(bus.sample), 8'h0);
    for (int j = 0; j < 15; j++) begin
      chk("ab_nodone", 8'(bus.done), 8'h0);
      tick(1);
    end

    // start held high with cont=0: one scan per IDLE entry
    d         = 4'b0011;
    bus.start = 1'b1;
    tick(1);
    tick(20);
    chk("h1_done",   8'(bus.done),   8'h1);
    chk("h1_sample", 8'(bus.sample), 8'h3);
    tick(1);
    chk("h1_idle", 8'(bus.busy), 8'h0);
    tick(1);
    bus.start = 1'b0;
    chk("h2_busy", 8'(bus.busy), 8'h1);
    chk("h2_sel",  8'(bus.sel),  8'h0);
    d = 4'b1100;
    tick(20);
    chk("h2_done",   8'(bus.done),   8'h1);
    chk("h2_sample", 8'(bus.sample), 8'hc);
    tick(1);
    chk("h2_idle", 8'(bus.busy), 8'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
